// File: rtl/risc_cpu8.sv
// 8-bit accumulator CPU with a unified 32x8 memory, serial load mode and a fetch/execute engine.
// Optional macro RISC_CPU8_MEM_CLEAR_EN: reset also clears every memory word.
module risc_cpu8 (
    input  logic       clock,
    input  logic       reset,
    input  logic       Load,
    input  logic [7:0] data_in,
    output logic [7:0] Instruction,
    output logic [7:0] Acc,
    output logic [7:0] Mem,
    output logic [4:0] Program_counter
);

    localparam int MEM_DEPTH = 32;
    localparam int DATA_W    = 8;

    typedef enum logic {
        FETCH,
        EXEC
    } state_t;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    logic [4:0]        pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [4:0]        load_ptr_q, load_ptr_d;
    state_t            state_q, state_d;
    logic              halted_q, halted_d;

    logic              mem_we;
    logic [4:0]        mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [4:0]        operand_addr;
    logic [DATA_W-1:0] operand;

    assign operand_addr = ir_q[4:0];
    assign operand      = mem_q[operand_addr];

    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        acc_d      = acc_q;
        load_ptr_d = load_ptr_q;
        state_d    = state_q;
        halted_d   = halted_q;
        mem_we     = 1'b0;
        mem_waddr  = load_ptr_q;
        mem_wdata  = data_in;

        if (Load) begin
            mem_we     = 1'b1;
            load_ptr_d = load_ptr_q + 5'd1;
            state_d    = FETCH;
            halted_d   = 1'b0;
        end else if (!halted_q) begin
            unique case (state_q)
                FETCH: begin
                    ir_d    = mem_q[pc_q];
                    pc_d    = pc_q + 5'd1;
                    state_d = EXEC;
                end
                EXEC: begin
                    state_d = FETCH;
                    unique case (ir_q[7:5])
                        OP_HLT: begin
                            halted_d = 1'b1;
                            state_d  = EXEC;
                        end
                        OP_SKZ: if (acc_q == '0) pc_d = pc_q + 5'd1;
                        OP_ADD: acc_d = acc_q + operand;
                        OP_AND: acc_d = acc_q & operand;
                        OP_XOR: acc_d = acc_q ^ operand;
                        OP_LDA: acc_d = operand;
                        OP_STO: begin
                            mem_we    = 1'b1;
                            mem_waddr = operand_addr;
                            mem_wdata = acc_q;
                        end
                        OP_JMP: pc_d = operand_addr;
                        default: ;
                    endcase
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // Reset wins over both write sources, so an aborted STO never reaches memory.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q       <= '0;
            ir_q       <= '0;
            acc_q      <= '0;
            load_ptr_q <= '0;
            state_q    <= FETCH;
            halted_q   <= 1'b0;
`ifdef RISC_CPU8_MEM_CLEAR_EN
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`else
`endif
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            acc_q      <= acc_d;
            load_ptr_q <= load_ptr_d;
            state_q    <= state_d;
            halted_q   <= halted_d;
            if (mem_we) begin
                mem_q[mem_waddr] <= mem_wdata;
            end
        end
    end

    assign Instruction     = ir_q;
    assign Acc             = acc_q;
    assign Mem             = operand;
    assign Program_counter = pc_q;

endmodule

// File: tb/tb_risc_cpu8.sv
// Self-checking bench for risc_cpu8: instruction-level reference model, per-cycle compare,
// directed programs with hand-computed results, then randomized programs.
module tb_risc_cpu8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       Load = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] Instruction;
    logic [7:0] Acc;
    logic [7:0] Mem;
    logic [4:0] Program_counter;

    int total = 0;
    int bad = 0;

    logic [7:0] prog [32];

    // Reference model state, kept as plain integers.
    int  m_mem [32];
    bit  m_known [32];
    int  m_pc, m_ir, m_acc, m_lp;
    bit  m_mid, m_halt, m_valid;

    risc_cpu8 dut (
        .clock           (clock),
        .reset           (reset),
        .Load            (Load),
        .data_in         (data_in),
        .Instruction     (Instruction),
        .Acc             (Acc),
        .Mem             (Mem),
        .Program_counter (Program_counter)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%02h expected=%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one call per rising edge, following the architectural rules.
    always @(posedge clock) begin
        if (reset === 1'b0) begin
            m_pc = 0; m_ir = 0; m_acc = 0; m_lp = 0;
            m_mid = 0; m_halt = 0; m_valid = 1;
`ifdef RISC_CPU8_MEM_CLEAR_EN
            for (int i = 0; i < 32; i++) begin
                m_mem[i] = 0;
                m_known[i] = 1;
            end
`endif
        end else if (Load === 1'b1) begin
            m_mem[m_lp] = int'(data_in);
            m_known[m_lp] = 1;
            m_lp = (m_lp + 1) % 32;
            m_mid = 0;
            m_halt = 0;
        end else if (!m_halt) begin
            if (!m_mid) begin
                m_ir = m_mem[m_pc];
                m_pc = (m_pc + 1) % 32;
                m_mid = 1;
            end else begin
                int a, m;
                a = m_ir % 32;
                m = m_mem[a];
                case (m_ir / 32)
                    0: m_halt = 1;
                    1: if (m_acc == 0) m_pc = (m_pc + 1) % 32;
                    2: m_acc = (m_acc + m) % 256;
                    3: m_acc = m_acc & m;
                    4: m_acc = m_acc ^ m;
                    5: m_acc = m;
                    6: begin m_mem[a] = m_acc; m_known[a] = 1; end
                    default: m_pc = a;
                endcase
                if (!m_halt) m_mid = 0;
            end
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check_output("model_ir", Instruction, 8'(m_ir));
            check_output("model_acc", Acc, 8'(m_acc));
            check_output("model_pc", {3'b000, Program_counter}, 8'(m_pc));
            if (m_known[m_ir % 32]) check_output("model_mem", Mem, 8'(m_mem[m_ir % 32]));
        end
    end

    task automatic apply_stimulus(input logic rst_n, input logic ld, input logic [7:0] din);
        reset = rst_n;
        Load = ld;
        data_in = din;
        @(posedge clock);
        #1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b0, 8'h00);
    endtask

    task automatic load_program();
        apply_stimulus(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 32; i++) apply_stimulus(1'b1, 1'b1, prog[i]);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 32; i++) prog[i] = 8'h00;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = 0;
            m_known[i] = 0;
        end
        m_valid = 0;
        @(posedge clock);
        #1;

        // Reset then partial load
        apply_stimulus(1'b0, 1'b0, 8'h00);
        check_output("rst_pc", {3'b000, Program_counter}, 8'h00);
        check_output("rst_acc", Acc, 8'h00);
        check_output("rst_ir", Instruction, 8'h00);
        apply_stimulus(1'b1, 1'b1, 8'hA2);
        check_output("load_mem0", Mem, 8'hA2);
        apply_stimulus(1'b1, 1'b1, 8'h00);
        apply_stimulus(1'b1, 1'b1, 8'h00);
        apply_stimulus(1'b1, 1'b1, 8'h0F);
        check_output("load_pc", {3'b000, Program_counter}, 8'h00);
        check_output("load_acc", Acc, 8'h00);
        check_output("load_ir", Instruction, 8'h00);

        // LDA/ADD with wrap, then halt
        clear_prog();
        prog[0] = 8'hA4; prog[1] = 8'h45; prog[2] = 8'h00; prog[4] = 8'hFF; prog[5] = 8'h02;
        load_program();
        run_cycles(2);
        check_output("lda_acc", Acc, 8'hFF);
        run_cycles(2);
        check_output("add_wrap_acc", Acc, 8'h01);
        run_cycles(24);
        check_output("halt_pc", {3'b000, Program_counter}, 8'h03);
        check_output("halt_acc", Acc, 8'h01);

        // AND/XOR giving zero, SKZ skips the HLT
        clear_prog();
        prog[0] = 8'hB0; prog[1] = 8'h71; prog[2] = 8'h92; prog[3] = 8'h20;
        prog[16] = 8'hAA; prog[17] = 8'hFF; prog[18] = 8'hAA;
        load_program();
        run_cycles(8);
        check_output("skz_taken_acc", Acc, 8'h00);
        check_output("skz_taken_pc", {3'b000, Program_counter}, 8'h05);
        run_cycles(6);
        check_output("skz_taken_halt_pc", {3'b000, Program_counter}, 8'h06);

        // Same program with a nonzero result: SKZ falls through to the HLT
        prog[18] = 8'h55;
        load_program();
        run_cycles(8);
        check_output("skz_not_acc", Acc, 8'hFF);
        check_output("skz_not_pc", {3'b000, Program_counter}, 8'h04);
        run_cycles(6);
        check_output("skz_not_halt_pc", {3'b000, Program_counter}, 8'h05);

        // STO then read back
        clear_prog();
        prog[0] = 8'hB0; prog[1] = 8'hDD; prog[2] = 8'hBD; prog[3] = 8'h00;
        prog[16] = 8'h5A; prog[29] = 8'h11;
        load_program();
        run_cycles(3);
        check_output("sto_pre_mem", Mem, 8'h11);
        run_cycles(2);
        check_output("sto_ir", Instruction, 8'hBD);
        check_output("sto_readback_mem", Mem, 8'h5A);
        run_cycles(1);
        check_output("sto_readback_acc", Acc, 8'h5A);

        // JMP to the last word and PC wrap
        clear_prog();
        prog[0] = 8'hFF; prog[31] = 8'hB0; prog[16] = 8'h3C;
        load_program();
        run_cycles(2);
        check_output("jmp_pc", {3'b000, Program_counter}, 8'h1F);
        run_cycles(1);
        check_output("wrap_pc", {3'b000, Program_counter}, 8'h00);
        check_output("wrap_ir", Instruction, 8'hB0);
        run_cycles(1);
        check_output("wrap_acc", Acc, 8'h3C);
        run_cycles(20);
        check_output("loop_pc", {3'b000, Program_counter}, 8'h00);

        // Reset during the EXEC of a STO
        clear_prog();
        prog[0] = 8'hB0; prog[1] = 8'hD1; prog[2] = 8'h00;
        prog[16] = 8'h77; prog[17] = 8'h33;
        load_program();
        run_cycles(3);
        check_output("pre_abort_ir", Instruction, 8'hD1);
        apply_stimulus(1'b0, 1'b0, 8'h00);
        check_output("abort_pc", {3'b000, Program_counter}, 8'h00);
        check_output("abort_acc", Acc, 8'h00);
        check_output("abort_ir", Instruction, 8'h00);
`ifdef RISC_CPU8_MEM_CLEAR_EN
        check_output("abort_clear_mem0", Mem, 8'h00);
        run_cycles(1);
        check_output("abort_clear_fetch", Instruction, 8'h00);
`else
        run_cycles(3);
        check_output("abort_refetch_ir", Instruction, 8'hD1);
        check_output("abort_no_write", Mem, 8'h33);
`endif

        // Randomized programs with sporadic load bursts and resets
        for (int iter = 0; iter < 12; iter++) begin
            for (int i = 0; i < 32; i++) prog[i] = 8'($urandom);
            load_program();
            for (int c = 0; c < 150; c++) begin
                int r;
                r = int'($urandom_range(0, 99));
                if (r < 2) apply_stimulus(1'b0, 1'($urandom), 8'($urandom));
                else if (r < 6) apply_stimulus(1'b1, 1'b1, 8'($urandom));
                else apply_stimulus(1'b1, 1'b0, 8'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/risc_cpu8.md
Name: risc_cpu8

Overview:
- 8-bit accumulator CPU with a unified 32x8 instruction/data memory.
- Instruction format: opcode in bits [7:5], operand address in bits [4:0].
- Two operating modes:
  - Load mode: memory is filled serially from data_in.
  - Run mode: a two-state fetch/execute engine runs the program.
- Internal state is exported for debug and verification.

Parameters:
- MEM_DEPTH, 32, number of memory words; fixed to 2^5 by the 5-bit address field.
- DATA_W, 8, data, accumulator and instruction width.

Ports:
- clock  input  1  rising-edge system clock
- reset  input  1  synchronous, active-low reset
- Load  input  1  1 = load mode (write data_in to memory); 0 = run mode
- data_in  input  8  word written to memory in load mode
- Instruction  output  8  current instruction register (IR)
- Acc  output  8  accumulator
- Mem  output  8  combinational read of mem[IR[4:0]]
- Program_counter  output  5  program counter (PC)

Behaviour:
- All registers update on the rising edge of clock.
- Reset (reset==0 at a clock edge):
  - PC, IR, Acc and the load pointer go to 0.
  - state goes to FETCH; halted flag is cleared.
  - Memory contents are kept (unless the optional feature below is enabled).
  - Reset has priority over Load and over execution.
  - Asserting reset mid-instruction aborts that instruction; no memory write occurs in that cycle.
- Load mode (reset==1, Load==1), each cycle:
  - mem[load_ptr] <= data_in; load_ptr <= load_ptr+1, wrapping 31->0.
  - PC, IR and Acc are held; state is forced to FETCH; halted is cleared.
  - load_ptr is only cleared by reset.
- Run mode (reset==1, Load==0, not halted):
  - FETCH: IR <= mem[PC]; PC <= PC+1 (mod 32); next state EXEC.
  - EXEC: decode IR[7:5] with A=IR[4:0], M=mem[A]; next state FETCH unless halted.
- Opcodes executed in EXEC:
  - 000 HLT: set halted. PC and all registers freeze until reset or Load.
  - 001 SKZ: if Acc==0 then PC <= PC+1 (skip the next word); else no change.
  - 010 ADD: Acc <= Acc+M, modulo 256; carry discarded.
  - 011 AND: Acc <= Acc & M.
  - 100 XOR: Acc <= Acc ^ M.
  - 101 LDA: Acc <= M.
  - 110 STO: mem[A] <= Acc in the EXEC cycle; Acc unchanged.
  - 111 JMP: PC <= A.
- Timing and visibility:
  - Every instruction takes exactly 2 cycles.
  - PC wraps 31->0.
  - Mem is combinational: it reflects a STO write in the cycle after that write.
- Memory: single write port (load or STO; never both, since load mode suppresses execution) and two read ports (fetch and Mem/operand), all asynchronous read.
- Cycle 1 after reset release fetches address 0.

Optional Feature:
- Macro: RISC_CPU8_MEM_CLEAR_EN.
- Defined: synchronous reset also clears all 32 memory words to 0x00 in the same cycle.
- Not defined: reset leaves memory unchanged.

Test Plan:
- Reset then load: reset=0 for one edge, then Load=1 with 4 words 0xA2,0x00,0x00,0x0F → mem[0..3] hold these; PC=0, Acc=0, Instruction=0x00 throughout.
- LDA/ADD wrap: mem[0]=0xA4 (LDA 4), mem[1]=0x45 (ADD 5), mem[2]=0x00 (HLT), mem[4]=0xFF, mem[5]=0x02; Load=0 → Acc=0xFF after cycle 2, Acc=0x01 after cycle 4; then halts with PC=3, staying frozen 20+ cycles.
- AND/XOR/SKZ: load Acc=0xAA, AND with 0xFF, XOR with 0xAA → Acc=0x00; SKZ skips the following HLT (PC advances by 2); when Acc≠0, the same SKZ does not skip and the HLT executes.
- STO then read-back: Acc=0x5A, STO 0x1D → mem[0x1D]=0x5A; a following LDA 0x1D shows Mem=0x5A and Acc=0x5A.
- JMP and PC wrap: JMP 0x1F followed by a non-HLT word at 0x1F → fetch at PC=0x1F, then PC=0x00. JMP 0x00 loop → PC returns to 0.
- Mid-run reset: reset=0 during an EXEC of STO → no memory write; PC=0, Acc=0, IR=0; execution restarts at address 0. With RISC_CPU8_MEM_CLEAR_EN, all memory words read 0x00 afterward.
